// File: rtl/hnoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hnoc_pkg
// Description : Shared HNoC definitions. Flit field layout helpers,
//               destination-pattern codes, send FSM states and the
//               16-bit Fibonacci LFSR step used for random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
package hnoc_pkg;

    // Widest flit the helper functions can pack or unpack
    localparam int c_FLIT_MAX = 64;

    // Base seed for the random-destination LFSR (XORed with the PE address)
    localparam logic [15:0] c_LFSR_SEED_BASE = 16'hACE1;

    typedef enum logic [1:0] {
        PAT_NEIGHBOUR  = 2'd0,
        PAT_COMPLEMENT = 2'd1,
        PAT_RANDOM     = 2'd2
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_FINISHED = 2'd2
    } send_state_e;

    // Flit layout: {dest[aw], src[aw], seq[dw-aw]}; dest sits just above the payload
    function automatic int dest_lsb(input int dw);
        return dw;
    endfunction

    // Source address occupies the top aw bits of the payload
    function automatic int src_lsb(input int dw, input int aw);
        return dw - aw;
    endfunction

    function automatic logic [c_FLIT_MAX-1:0] field_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [c_FLIT_MAX-1:0] make_flit(
        input logic [c_FLIT_MAX-1:0] dest,
        input logic [c_FLIT_MAX-1:0] src,
        input logic [c_FLIT_MAX-1:0] seq,
        input int                    dw,
        input int                    aw
    );
        return ((dest & field_mask(aw)) << dest_lsb(dw))
             | ((src  & field_mask(aw)) << src_lsb(dw, aw))
             |  (seq  & field_mask(dw - aw));
    endfunction

    function automatic logic [c_FLIT_MAX-1:0] get_dest(
        input logic [c_FLIT_MAX-1:0] flit,
        input int                    dw,
        input int                    aw
    );
        return (flit >> dest_lsb(dw)) & field_mask(aw);
    endfunction

    function automatic logic [c_FLIT_MAX-1:0] get_src(
        input logic [c_FLIT_MAX-1:0] flit,
        input int                    dw,
        input int                    aw
    );
        return (flit >> src_lsb(dw, aw)) & field_mask(aw);
    endfunction

    function automatic logic [c_FLIT_MAX-1:0] get_seq(
        input logic [c_FLIT_MAX-1:0] flit,
        input int                    dw,
        input int                    aw
    );
        return flit & field_mask(dw - aw);
    endfunction

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage : hnoc_pkg
`default_nettype wire

// File: rtl/hnoc_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : hnoc_lfsr16
// Description : 16-bit Fibonacci LFSR. Loads its seed in reset and steps
//               once per asserted advance. A zero seed is replaced so the
//               register can never lock up at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hnoc_lfsr16
    import hnoc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] w_seed;
    logic [15:0] value_q;

    assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

    // Seed on reset, step on each advance request
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= w_seed;
        end else if (advance) begin
            value_q <= lfsr16_step(value_q);
        end
    end

    assign value = value_q;

endmodule : hnoc_lfsr16
`default_nettype wire

// File: rtl/hnoc_pe.sv
`default_nettype none
// ============================================================================
// Module      : hnoc_pe
// Description : HNoC traffic processing element. Injects PktLmit addressed
//               flits using a Neighbour / Complement / Random destination
//               pattern and sinks (counts) every flit delivered to it.
// Revision    : 1.0 - initial release
// ============================================================================
module hnoc_pe
    import hnoc_pkg::*;
#(
    parameter int    address      = 0,
    parameter int    numPE        = 8,
    parameter int    AddressWidth = 3,
    parameter int    DataWidth    = 32,
    parameter int    TotalWidth   = 35,
    parameter int    PktLmit      = 100,
    parameter string Pattern      = "Neighbour"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TotalWidth-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [TotalWidth-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    input  logic                  done
);

    // Pattern string resolved once at elaboration; anything unknown falls back to Neighbour
    localparam pattern_e c_PAT =
        (Pattern == "Complement") ? PAT_COMPLEMENT :
        (Pattern == "Random")     ? PAT_RANDOM     : PAT_NEIGHBOUR;

    localparam logic [31:0] c_PKT_LIMIT = 32'(PktLmit);
    localparam logic [15:0] c_SEED      = c_LFSR_SEED_BASE ^ 16'(address);
    localparam int          c_NEIGHBOUR = (address + 1) % numPE;
    localparam int          c_COMPLEMENT = (numPE - 1) - address;

    send_state_e           state_q, state_d;
    logic                  valid_q, valid_d;
    logic [TotalWidth-1:0] data_q,  data_d;
    logic [31:0]           sent_q,  sent_d;
    logic [31:0]           received_q;
    logic                  ready_q;
    logic                  done_q;

    logic                  w_done_any;
    logic                  w_lfsr_adv;
    logic [15:0]           w_lfsr_value;
    logic [15:0]           w_lfsr_next;

    // Destination selection; lfsr_low is only consulted for the Random pattern
    function automatic logic [AddressWidth-1:0] dest_of(input logic [AddressWidth-1:0] lfsr_low);
        int d;
        case (c_PAT)
            PAT_COMPLEMENT: d = c_COMPLEMENT;
            PAT_RANDOM: begin
                d = int'(lfsr_low) % numPE;
                if (d == address) begin
                    d = c_NEIGHBOUR;
                end
            end
            default: d = c_NEIGHBOUR;
        endcase
        return AddressWidth'(d);
    endfunction

    function automatic logic [TotalWidth-1:0] build_flit(
        input logic [AddressWidth-1:0] dest,
        input logic [31:0]             seq
    );
        return TotalWidth'(make_flit(64'(dest), 64'(address), 64'(seq), DataWidth, AddressWidth));
    endfunction

    generate
        if (c_PAT == PAT_RANDOM) begin : g_random
            hnoc_lfsr16 u_lfsr (
                .clk     (clk),
                .rst     (rst),
                .seed    (c_SEED),
                .advance (w_lfsr_adv),
                .value   (w_lfsr_value)
            );
        end else begin : g_fixed
            assign w_lfsr_value = 16'h0000;
        end
    endgenerate

    // The flit following a transfer must use the LFSR value after this transfer's step
    assign w_lfsr_next = lfsr16_step(w_lfsr_value);
    // done is sticky: once seen, both directions stay quiet until reset
    assign w_done_any  = done | done_q;

    // Send FSM next-state: first flit out of IDLE, back-to-back in SEND, halt in FINISHED
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        sent_d     = sent_q;
        w_lfsr_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_done_any || (c_PKT_LIMIT == 32'd0)) begin
                    valid_d = 1'b0;
                    state_d = ST_FINISHED;
                end else begin
                    valid_d = 1'b1;
                    data_d  = build_flit(dest_of(w_lfsr_value[AddressWidth-1:0]), 32'd0);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_done_any) begin
                    valid_d = 1'b0;
                    state_d = ST_FINISHED;
                end else if (valid_q && i_data_ready) begin
                    sent_d     = sent_q + 32'd1;
                    w_lfsr_adv = 1'b1;
                    if (sent_d < c_PKT_LIMIT) begin
                        data_d = build_flit(dest_of(w_lfsr_next[AddressWidth-1:0]), sent_d);
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_FINISHED;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_FINISHED;
            end
        endcase
    end

    // Send-side and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= 32'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            ready_q <= ~w_done_any;
            done_q  <= w_done_any;
        end
    end

    // Receive counter: every accepted delivery is counted, independent of sending
    always_ff @(posedge clk) begin
        if (rst) begin
            received_q <= 32'd0;
        end else if (i_data_valid && ready_q) begin
            received_q <= received_q + 32'd1;
        end
    end

`ifndef SYNTHESIS
    int misroute_q;

    // Simulation aid: report and count flits delivered to the wrong PE
    always_ff @(posedge clk) begin
        if (rst) begin
            misroute_q <= 0;
        end else if (i_data_valid && ready_q &&
                     (get_dest(64'(i_data), DataWidth, AddressWidth) != 64'(address))) begin
            misroute_q <= misroute_q + 1;
            $display("hnoc_pe[%0d] error: misrouted flit dest=%0d src=%0d seq=%0d", address,
                     get_dest(64'(i_data), DataWidth, AddressWidth),
                     get_src(64'(i_data), DataWidth, AddressWidth),
                     get_seq(64'(i_data), DataWidth, AddressWidth));
        end
    end
`endif

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_data_ready = ready_q;

endmodule : hnoc_pe
`default_nettype wire

// File: tb/tb_hnoc_pe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hnoc_pe
// Description : Self-checking bench for hnoc_pe. A main PE (address 3,
//               Neighbour) plus fixed-ready PEs covering Neighbour wrap,
//               Complement and Random destination patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hnoc_pe;

    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int TW  = 35;
    localparam int LIM = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic          rdy = 1'b0;
    logic          rx_valid = 1'b0;
    logic [TW-1:0] rx_data = '0;
    logic          one = 1'b1;
    logic          zero = 1'b0;
    logic [TW-1:0] zflit = '0;

    logic          m_ready, m_valid;
    logic [TW-1:0] m_data;
    logic          w_ready, w_valid, c_ready, c_valid, r_ready, r_valid;
    logic [TW-1:0] w_data, c_data, r_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0] exp_m[$];
    logic [TW-1:0] exp_w[$];
    logic [TW-1:0] exp_c[$];
    logic [TW-1:0] exp_r[$];

    always #5 clk = ~clk;

    hnoc_pe #(.address(3), .numPE(8), .AddressWidth(AW), .DataWidth(DW), .TotalWidth(TW),
              .PktLmit(LIM), .Pattern("Neighbour")) u_main (
        .clk(clk), .rst(rst), .i_data(rx_data), .i_data_valid(rx_valid), .o_data_ready(m_ready),
        .o_data(m_data), .o_data_valid(m_valid), .i_data_ready(rdy), .done(done));

    hnoc_pe #(.address(7), .numPE(8), .AddressWidth(AW), .DataWidth(DW), .TotalWidth(TW),
              .PktLmit(LIM), .Pattern("Neighbour")) u_wrap (
        .clk(clk), .rst(rst), .i_data(zflit), .i_data_valid(zero), .o_data_ready(w_ready),
        .o_data(w_data), .o_data_valid(w_valid), .i_data_ready(one), .done(zero));

    hnoc_pe #(.address(2), .numPE(8), .AddressWidth(AW), .DataWidth(DW), .TotalWidth(TW),
              .PktLmit(LIM), .Pattern("Complement")) u_comp (
        .clk(clk), .rst(rst), .i_data(zflit), .i_data_valid(zero), .o_data_ready(c_ready),
        .o_data(c_data), .o_data_valid(c_valid), .i_data_ready(one), .done(zero));

    hnoc_pe #(.address(3), .numPE(8), .AddressWidth(AW), .DataWidth(DW), .TotalWidth(TW),
              .PktLmit(LIM), .Pattern("Random")) u_rand (
        .clk(clk), .rst(rst), .i_data(zflit), .i_data_valid(zero), .o_data_ready(r_ready),
        .o_data(r_data), .o_data_valid(r_valid), .i_data_ready(one), .done(zero));

    function automatic logic [TW-1:0] mk(input int d, input int s, input int q);
        logic [2:0]  dd;
        logic [2:0]  ss;
        logic [28:0] qq;
        dd = d[2:0];
        ss = s[2:0];
        qq = q[28:0];
        return {dd, ss, qq};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; done = 1'b0; rdy = 1'b0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data  = mk(3, 0, 5);
        repeat (3) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", m_data); end
        n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", m_ready); end
        n_checks++; if (u_main.received_q !== 32'd0) begin n_fail++; $display("FAIL reset_received got=%0d exp=0", u_main.received_q); end
        rx_valid = 1'b0;
    endtask

    task automatic test_patterns();
        int got_m = 0, got_w = 0, got_c = 0, got_r = 0, first = -1, last = -1;
        logic [15:0] lf;
        logic [TW-1:0] e;
        int d;
        exp_m.delete(); exp_w.delete(); exp_c.delete(); exp_r.delete();
        lf = 16'hACE1 ^ 16'd3;
        for (int i = 0; i < LIM; i++) begin
            exp_m.push_back(mk(4, 3, i));
            exp_w.push_back(mk(0, 7, i));
            exp_c.push_back(mk(5, 2, i));
            d = int'(lf[2:0]) % 8;
            if (d == 3) d = 4;
            exp_r.push_back(mk(d, 3, i));
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
        do_reset();
        for (int cyc = 0; cyc < 400 && !(got_m == LIM && got_w == LIM && got_c == LIM && got_r == LIM); cyc++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (m_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                e = (exp_m.size() > 0) ? exp_m.pop_front() : 'x;
                n_checks++; if (m_data !== e) begin n_fail++; $display("FAIL neighbour_flit got=%h exp=%h", m_data, e); end
                got_m++;
            end
            if (w_valid) begin
                e = (exp_w.size() > 0) ? exp_w.pop_front() : 'x;
                n_checks++; if (w_data !== e) begin n_fail++; $display("FAIL wrap_flit got=%h exp=%h", w_data, e); end
                got_w++;
            end
            if (c_valid) begin
                e = (exp_c.size() > 0) ? exp_c.pop_front() : 'x;
                n_checks++; if (c_data !== e) begin n_fail++; $display("FAIL complement_flit got=%h exp=%h", c_data, e); end
                got_c++;
            end
            if (r_valid) begin
                e = (exp_r.size() > 0) ? exp_r.pop_front() : 'x;
                n_checks++; if (r_data !== e) begin n_fail++; $display("FAIL random_flit got=%h exp=%h", r_data, e); end
                n_checks++; if (r_data[TW-1 -: AW] === 3'd3) begin n_fail++; $display("FAIL random_self_dest got=%0d exp!=3", r_data[TW-1 -: AW]); end
                got_r++;
            end
        end
        n_checks++; if (got_m != LIM || got_w != LIM || got_c != LIM || got_r != LIM) begin
            n_fail++; $display("FAIL pattern_count got=%0d/%0d/%0d/%0d exp=%0d", got_m, got_w, got_c, got_r, LIM);
        end
        n_checks++; if (last - first + 1 != LIM) begin n_fail++; $display("FAIL back_to_back got=%0d cycles exp=%0d", last - first + 1, LIM); end
        @(negedge clk);
        n_checks++; if ({m_valid, w_valid, c_valid, r_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL valid_after_limit got=%b exp=0000", {m_valid, w_valid, c_valid, r_valid});
        end
        repeat (3) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL valid_stays_low got=%b exp=0", m_valid); end
        rdy = 1'b0;
    endtask

    task automatic test_stall();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int got = 0, k = 0;
        bit held_v = 1'b0;
        logic [TW-1:0] held, e;
        exp_m.delete();
        for (int i = 0; i < 20; i++) exp_m.push_back(mk(4, 3, i));
        do_reset();
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                if (held_v) begin
                    n_checks++; if (m_data !== held) begin n_fail++; $display("FAIL stall_stable got=%h exp=%h", m_data, held); end
                end
                rdy = pat[k % 4];
                k++;
                if (rdy) begin
                    e = (exp_m.size() > 0) ? exp_m.pop_front() : 'x;
                    n_checks++; if (m_data !== e) begin n_fail++; $display("FAIL stall_flit got=%h exp=%h", m_data, e); end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held   = m_data;
                    held_v = 1'b1;
                end
            end else begin
                rdy = 1'b0;
            end
        end
        n_checks++; if (got != 20) begin n_fail++; $display("FAIL stall_count got=%0d exp=20", got); end
        rdy = 1'b0;
    endtask

    task automatic test_receive();
        do_reset();
        @(negedge clk);
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready got=%b exp=1", m_ready); end
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = mk(3, i % 8, i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (u_main.received_q !== 32'd10) begin n_fail++; $display("FAIL rx_count got=%0d exp=10", u_main.received_q); end
        n_checks++; if (u_main.misroute_q != 0) begin n_fail++; $display("FAIL rx_no_error got=%0d exp=0", u_main.misroute_q); end
        rx_valid = 1'b1;
        rx_data  = mk(5, 1, 77);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (u_main.misroute_q != 1) begin n_fail++; $display("FAIL rx_error_seen got=%0d exp=1", u_main.misroute_q); end
        n_checks++; if (u_main.received_q !== 32'd11) begin n_fail++; $display("FAIL rx_count_bad got=%0d exp=11", u_main.received_q); end
    endtask

    task automatic test_done();
        int got = 0, rx_cnt = 0;
        logic [TW-1:0] e;
        exp_m.delete();
        for (int i = 0; i < LIM; i++) exp_m.push_back(mk(4, 3, i));
        do_reset();
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (got == 40) break;
            rdy      = 1'b1;
            rx_valid = 1'b1;
            rx_data  = mk(3, 1, cyc);
            if (m_ready) rx_cnt++;
            if (m_valid) begin
                e = exp_m.pop_front();
                n_checks++; if (m_data !== e) begin n_fail++; $display("FAIL done_flit got=%h exp=%h", m_data, e); end
                got++;
            end
        end
        rdy = 1'b0; rx_valid = 1'b0; done = 1'b1;
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0 || m_ready !== 1'b0) begin
            n_fail++; $display("FAIL done_stop got=%b%b exp=00", m_valid, m_ready);
        end
        n_checks++; if (u_main.sent_q !== 32'd40) begin n_fail++; $display("FAIL done_sent got=%0d exp=40", u_main.sent_q); end
        n_checks++; if (u_main.received_q !== 32'(rx_cnt)) begin
            n_fail++; $display("FAIL concurrent_rx got=%0d exp=%0d", u_main.received_q, rx_cnt);
        end
        done = 1'b0; rdy = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0 || m_ready !== 1'b0 || u_main.sent_q !== 32'd40) begin
            n_fail++; $display("FAIL done_sticky got=%b%b sent=%0d exp=00 sent=40", m_valid, m_ready, u_main.sent_q);
        end
        rdy = 1'b0;
    endtask

    task automatic test_rst_mid();
        int got = 0;
        logic [TW-1:0] e;
        exp_m.delete();
        for (int i = 0; i < 50; i++) exp_m.push_back(mk(4, 3, i));
        do_reset();
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (got == 50) break;
            rdy = 1'b1;
            if (m_valid) begin
                e = (exp_m.size() > 0) ? exp_m.pop_front() : 'x;
                n_checks++; if (m_data !== e) begin n_fail++; $display("FAIL pre_rst_flit got=%h exp=%h", m_data, e); end
                got++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0 || m_data !== '0 || m_ready !== 1'b0 || u_main.sent_q !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst got=%b %h %b %0d exp=0 0 0 0", m_valid, m_data, m_ready, u_main.sent_q);
        end
        rst = 1'b0;
        got = 0;
        exp_m.delete();
        for (int i = 0; i < LIM; i++) exp_m.push_back(mk(4, 3, i));
        for (int cyc = 0; cyc < 300 && got < LIM; cyc++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (m_valid) begin
                e = (exp_m.size() > 0) ? exp_m.pop_front() : 'x;
                n_checks++; if (m_data !== e) begin n_fail++; $display("FAIL post_rst_flit got=%h exp=%h", m_data, e); end
                got++;
            end
        end
        n_checks++; if (got != LIM) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=%0d", got, LIM); end
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_end got=%b exp=0", m_valid); end
        rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stall();
        test_receive();
        test_done();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hnoc_pe
`default_nettype wire
